// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer controller: state encoding, mode values and default width.
package timer_ctrl_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_counter_dp.sv
// Counter datapath: +1 adder with carry-out, reload/sum mux and enabled W-bit register.
module counter_dp #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic         EN,
  input  logic         LD,
  input  logic [W-1:0] D,
  output logic [W-1:0] O,
  output logic         COUT
);

  localparam logic [W:0] ONE = (W+1)'(1);

  logic [W:0]   w_sum_full;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_next;

  // Carry-out of O+1 is the terminal-count indication (O == all-ones).
  assign w_sum_full = {1'b0, O} + ONE;
  assign w_sum      = w_sum_full[W-1:0];
  assign COUT       = w_sum_full[W];
  assign w_next     = LD ? D : w_sum;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      O <= '0;
    end else if (EN) begin
      O <= w_next;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller around counter_dp: load handshake, start/stop, tick enable,
// terminal-count pulse and one-shot / periodic operation.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic         LOAD_VALID,
  output logic         LOAD_READY,
  input  logic [W-1:0] LOAD_DATA,
  input  logic         MODE,
  input  logic         START,
  input  logic         STOP,
  input  logic         CE,
  output logic [W-1:0] O,
  output logic         TC,
  output logic         BUSY,
  output logic         DONE
);

  // state    | meaning
  // IDLE     | no reload programmed, START ignored
  // ARMED    | reload programmed, waiting for START
  // RUN      | counting on CE
  // DONE     | one-shot finished, count parked at reload

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_reload;
  logic [W-1:0] w_reload_nxt;
  logic         r_mode_q;
  logic         w_mode_nxt;
  logic         r_tc;

  logic         w_cnt_en;
  logic         w_cnt_ld;
  logic [W-1:0] w_cnt_d;
  logic         w_cout;
  logic         w_wrap;
  logic         w_load_acc;
  logic         w_start_ok;

  counter_dp #(.W(W)) u_dp (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .EN          (w_cnt_en),
    .LD          (w_cnt_ld),
    .D           (w_cnt_d),
    .O           (O),
    .COUT        (w_cout)
  );

  assign w_wrap     = CE & w_cout;
  assign w_load_acc = LOAD_VALID & (r_state != ST_RUN);
  assign w_start_ok = START & ~STOP;

  always_comb begin
    w_state_nxt  = r_state;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode_q;
    w_cnt_en     = 1'b0;
    w_cnt_ld     = 1'b0;
    w_cnt_d      = r_reload;

    // A load outranks START in every state that can accept one.
    if (w_load_acc) begin
      w_state_nxt  = ST_ARMED;
      w_reload_nxt = LOAD_DATA;
      w_cnt_en     = 1'b1;
      w_cnt_ld     = 1'b1;
      w_cnt_d      = LOAD_DATA;
    end else begin
      unique case (r_state)
        ST_ARMED: begin
          if (w_start_ok) begin
            w_state_nxt = ST_RUN;
            w_mode_nxt  = MODE;
          end
        end
        ST_DONE: begin
          if (w_start_ok) begin
            w_state_nxt = ST_RUN;
            w_mode_nxt  = MODE;
            w_cnt_en    = 1'b1;
            w_cnt_ld    = 1'b1;
          end
        end
        ST_RUN: begin
          if (STOP) begin
            w_state_nxt = ST_ARMED;
            w_cnt_en    = 1'b1;
            w_cnt_ld    = 1'b1;
          end else if (CE) begin
            w_cnt_en = 1'b1;
            w_cnt_ld = w_cout;
            if (w_cout && (r_mode_q == MODE_ONESHOT)) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state  <= ST_IDLE;
      r_reload <= '0;
      r_mode_q <= MODE_ONESHOT;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_reload <= w_reload_nxt;
      r_mode_q <= w_mode_nxt;
      // TC pulses on a wrap in RUN even when STOP takes the state elsewhere.
      r_tc     <= (r_state == ST_RUN) & w_wrap;
    end
  end

  assign TC         = r_tc;
  assign BUSY       = (r_state == ST_RUN);
  assign DONE       = (r_state == ST_DONE);
  assign LOAD_READY = (r_state != ST_RUN);

endmodule
